// File: rtl/tc_div_29s_11ns_seq.sv
// tc_div_29s_11ns_seq: sequential signed/unsigned restoring divider with saturated quotient and signed remainder
module tc_div_29s_11ns_seq #(
  parameter int ID         = 1,
  parameter int din0_WIDTH = 29,
  parameter int din1_WIDTH = 11,
  parameter int dout_WIDTH = 18
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] quot,
  output logic [11:0]           rem,
  output logic                  ovf,
  output logic                  dbz
);
  if (din0_WIDTH != 29 || din1_WIDTH != 11 || dout_WIDTH != 18 || ID < 0) begin : g_bad_cfg
    $error("tc_div_29s_11ns_seq supports only 29/11/18 widths");
  end
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state, nxt;
  logic        neg, zero;
  logic [28:0] mag, qm;
  logic [10:0] dv;
  logic [11:0] pr, sh;
  logic [4:0]  cnt;
  logic        ge, ovf_n;
  logic [17:0] quot_n;
  logic [11:0] rem_n;
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign sh = {pr[10:0], mag[28]};
  assign ge = sh >= {1'b0, dv};
  // state register
  always_ff @(posedge ap_clk)
    state <= ap_rst ? IDLE : nxt;
  // next-state logic
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (in_valid) nxt = (din1 == '0) ? FIX : CALC;
      CALC: if (cnt == 5'd28) nxt = FIX;
      FIX:  nxt = DONE;
      DONE: if (out_ready) nxt = IDLE;
    endcase
  end
  // sign application and saturation of the finished magnitude
  always_comb begin
    ovf_n  = !zero && (neg ? qm > 29'd131072 : qm > 29'd131071);
    quot_n = (zero || ovf_n) ? (neg ? 18'h20000 : 18'h1ffff) : (neg ? -qm[17:0] : qm[17:0]);
    rem_n  = zero ? 12'd0 : (neg ? -pr : pr);
  end
  // operand capture, one restoring step per CALC cycle, result registers
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      {neg, zero, mag, qm, dv, pr, cnt} <= '0;
      {quot, rem, ovf, dbz} <= '0;
    end else begin
      if (state == IDLE && in_valid) begin
        neg  <= din0[28];
        zero <= din1 == '0;
        mag  <= din0[28] ? -din0 : din0;
        dv   <= din1;
        pr   <= '0;
        qm   <= '0;
        cnt  <= '0;
      end
      if (state == CALC) begin
        pr  <= ge ? sh - {1'b0, dv} : sh;
        qm  <= {qm[27:0], ge};
        mag <= {mag[27:0], 1'b0};
        cnt <= cnt + 5'd1;
      end
      if (state == FIX) begin
        quot <= quot_n;
        rem  <= rem_n;
        ovf  <= ovf_n;
        dbz  <= zero;
      end
    end
  end
endmodule
